// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream packet buffer:
//   - default field widths and buffer depth
//   - beat_t : one stored beat {data, qos, id, last} at the default widths
//   - state_t: store-and-forward / cut-through mode of the packet buffer
// -----------------------------------------------------------------------------
package stream_pkg;

    localparam int DEF_DATA_WIDTH   = 4;
    localparam int DEF_QOS_WIDTH    = 2;
    localparam int DEF_STREAM_COUNT = 2;
    localparam int DEF_ID_WIDTH     = $clog2(DEF_STREAM_COUNT);
    localparam int DEF_DEPTH        = 8;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_QOS_WIDTH-1:0]  qos;
        logic [DEF_ID_WIDTH-1:0]   id;
        logic                      last;
    } beat_t;

    typedef enum logic [0:0] {
        ST_STORE = 1'b0,
        ST_CUT   = 1'b1
    } state_t;

endpackage

// File: rtl/stream_sync_fifo.sv
// -----------------------------------------------------------------------------
// stream_sync_fifo
// Generic single-clock first-word-fall-through FIFO built from flops.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  push (ignored while full)
//   rd_en, rd_data  pop (ignored while empty); rd_data shows the head entry
//   full, empty     occupancy flags derived from the registered level
//   level           number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module stream_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full    = (level_r == LVL_W'(DEPTH));
    assign empty   = (level_r == LVL_W'(0));
    assign level   = level_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Guard the handshakes so a misbehaving caller can never corrupt the pointers.
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;

    // Storage array and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
        end else if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        end
    end

    // Read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
        end else if (rd_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= '0;
        end else begin
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/stream_packet_buffer.sv
// -----------------------------------------------------------------------------
// stream_packet_buffer
// Store-and-forward packet FIFO placed after the QoS stream arbiter. A packet
// is presented to the consumer only once its last beat is stored. A packet that
// fills the whole buffer without a last beat switches the buffer to cut-through
// until that packet's last beat leaves, so oversized packets cannot deadlock.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_data_in/qos/id/last/valid_in  beat from the arbiter; s_ready_out accepts
//   m_data/qos/id/last/valid_out    head beat (FWFT), zero when not valid
//   m_ready_in                      consumer ready
//   pkt_count_out                   complete packets held (registered)
//   level_out                       beats held (registered)
// -----------------------------------------------------------------------------
module stream_packet_buffer
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int T_QOS__WIDTH = DEF_QOS_WIDTH,
    parameter int STREAM_COUNT = DEF_STREAM_COUNT,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int DEPTH        = DEF_DEPTH,
    localparam int CNT_W       = $clog2(DEPTH + 1),
    localparam int BEAT_W      = T_DATA_WIDTH + T_QOS__WIDTH + T_ID___WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_in,
    input  logic [T_QOS__WIDTH-1:0] s_qos_in,
    input  logic [T_ID___WIDTH-1:0] s_id_in,
    input  logic                    s_last_in,
    input  logic                    s_valid_in,
    output logic                    s_ready_out,
    output logic [T_DATA_WIDTH-1:0] m_data_out,
    output logic [T_QOS__WIDTH-1:0] m_qos_out,
    output logic [T_ID___WIDTH-1:0] m_id_out,
    output logic                    m_last_out,
    output logic                    m_valid_out,
    input  logic                    m_ready_in,
    output logic [CNT_W-1:0]        pkt_count_out,
    output logic [CNT_W-1:0]        level_out
);

    logic [BEAT_W-1:0]       wr_beat_s;
    logic [BEAT_W-1:0]       rd_beat_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [CNT_W-1:0]        level_s;
    logic [T_DATA_WIDTH-1:0] head_data_s;
    logic [T_QOS__WIDTH-1:0] head_qos_s;
    logic [T_ID___WIDTH-1:0] head_id_s;
    logic                    head_last_s;
    logic                    ready_r;
    logic [CNT_W-1:0]        pkt_count_r;
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    cut_through_s;
    logic                    wr_en_s;
    logic                    rd_en_s;
    logic                    m_valid_s;

    assign wr_beat_s = {s_data_in, s_qos_in, s_id_in, s_last_in};
    assign {head_data_s, head_qos_s, head_id_s, head_last_s} = rd_beat_s;

    // Ready looks only at the registered level, so a full buffer refuses a beat
    // even in a cycle where the head is being read.
    assign s_ready_out   = ready_r && !fifo_full_s;
    assign wr_en_s       = s_valid_in && s_ready_out;
    assign cut_through_s = (state_r == ST_CUT);
    assign m_valid_s     = !fifo_empty_s && ((pkt_count_r != '0) || cut_through_s);
    assign rd_en_s       = m_valid_s && m_ready_in;

    assign m_valid_out   = m_valid_s;
    assign pkt_count_out = pkt_count_r;
    assign level_out     = level_s;

    stream_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_data (wr_beat_s),
        .rd_en   (rd_en_s),
        .rd_data (rd_beat_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (level_s)
    );

    // Input ready comes up one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // Complete-packet counter: a stored last beat adds one, a read last beat
    // removes one. It never exceeds the level, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_r <= '0;
        end else begin
            case ({wr_en_s && s_last_in, rd_en_s && head_last_s})
                2'b10:   pkt_count_r <= pkt_count_r + CNT_W'(1);
                2'b01:   pkt_count_r <= pkt_count_r - CNT_W'(1);
                default: pkt_count_r <= pkt_count_r;
            endcase
        end
    end

    // Forwarding-mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_STORE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Forwarding-mode next state: a full buffer holding no complete packet can
    // only be an oversized packet, which is then streamed until its last beat
    // has been read.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STORE: begin
                if (fifo_full_s && (pkt_count_r == '0)) begin
                    state_nxt_s = ST_CUT;
                end else begin
                    state_nxt_s = ST_STORE;
                end
            end
            ST_CUT: begin
                if (rd_en_s && head_last_s) begin
                    state_nxt_s = ST_STORE;
                end else begin
                    state_nxt_s = ST_CUT;
                end
            end
            default: state_nxt_s = ST_STORE;
        endcase
    end

    // Head beat is shown only while presentable, zero otherwise.
    always_comb begin
        m_data_out = '0;
        m_qos_out  = '0;
        m_id_out   = '0;
        m_last_out = 1'b0;
        if (m_valid_s) begin
            m_data_out = head_data_s;
            m_qos_out  = head_qos_s;
            m_id_out   = head_id_s;
            m_last_out = head_last_s;
        end else begin
            m_data_out = '0;
            m_qos_out  = '0;
            m_id_out   = '0;
            m_last_out = 1'b0;
        end
    end

endmodule
